// File: rtl/xc_pclmul_fu.sv
// Packed carry-less multiply unit for xc.pclmul.l / xc.pclmul.h.
// Operands split into lanes of 32/16/8/4/2 bits. Each lane pair is multiplied
// in parallel, one multiplier bit per cycle, into a 64-bit lane-partitioned
// accumulator. The low or high half of each lane product is packed into the result.
module xc_pclmul_fu (
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [2:0]  in_pw,
  input  logic        in_hi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] rs1_reg;
  logic [31:0] rs2_reg;
  logic [2:0]  pw_reg;
  logic        hi_reg;
  logic [63:0] acc_reg;
  logic [4:0]  count_reg;

  // One candidate next-accumulator and one packed result per lane width.
  logic [63:0] step_acc [5];
  logic [31:0] res_pack [5];

  logic [63:0] step_sel;
  logic [31:0] res_sel;
  logic [4:0]  last_count;
  logic        pw_reserved;

  assign pw_reserved = (pw_reg > 3'd4);

  // Each width gi gets its own lane slicing. Lanes are built independently,
  // so no bit can cross a lane boundary.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_width
      localparam int W  = 32 >> gi;
      localparam int LW = $clog2(W);
      localparam int NL = 32 / W;

      logic [63:0] step_w;
      logic [31:0] res_w;

      for (genvar gj = 0; gj < NL; gj++) begin : g_lane
        logic [W-1:0]   a_lane;
        logic [W-1:0]   b_lane;
        logic [2*W-1:0] acc_lane;
        logic [2*W-1:0] part;

        assign a_lane   = rs1_reg[W*gj +: W];
        assign b_lane   = rs2_reg[W*gj +: W];
        assign acc_lane = acc_reg[2*W*gj +: 2*W];
        // The count is always below W here, so the shifted multiplicand
        // always fits within the 2W-bit lane.
        assign part     = {{W{1'b0}}, a_lane} << count_reg[LW-1:0];

        assign step_w[2*W*gj +: 2*W] =
          acc_lane ^ (b_lane[count_reg[LW-1:0]] ? part : {(2*W){1'b0}});
        assign res_w[W*gj +: W] =
          hi_reg ? acc_lane[2*W-1:W] : acc_lane[W-1:0];
      end

      assign step_acc[gi] = step_w;
      assign res_pack[gi] = res_w;
    end
  endgenerate

  // Select the datapath slice and terminal count for the latched width.
  always_comb begin
    step_sel   = acc_reg;
    res_sel    = 32'd0;
    last_count = 5'd0;
    case (pw_reg)
      3'd0: begin step_sel = step_acc[0]; res_sel = res_pack[0]; last_count = 5'd31; end
      3'd1: begin step_sel = step_acc[1]; res_sel = res_pack[1]; last_count = 5'd15; end
      3'd2: begin step_sel = step_acc[2]; res_sel = res_pack[2]; last_count = 5'd7;  end
      3'd3: begin step_sel = step_acc[3]; res_sel = res_pack[3]; last_count = 5'd3;  end
      3'd4: begin step_sel = step_acc[4]; res_sel = res_pack[4]; last_count = 5'd1;  end
      default: begin
        step_sel   = acc_reg;
        res_sel    = 32'd0;
        last_count = 5'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_BUSY;
      end
      ST_BUSY: begin
        // A reserved width spends exactly one BUSY cycle so that its zero
        // result appears one edge after accept.
        if (pw_reserved || (count_reg == last_count)) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // Operand latches, accumulator and step counter.
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      rs1_reg   <= 32'd0;
      rs2_reg   <= 32'd0;
      pw_reg    <= 3'd0;
      hi_reg    <= 1'b0;
      acc_reg   <= 64'd0;
      count_reg <= 5'd0;
    end else if (flush) begin
      acc_reg   <= 64'd0;
      count_reg <= 5'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            rs1_reg   <= in_rs1;
            rs2_reg   <= in_rs2;
            pw_reg    <= in_pw;
            hi_reg    <= in_hi;
            acc_reg   <= 64'd0;
            count_reg <= 5'd0;
          end
        end
        ST_BUSY: begin
          if (!pw_reserved) begin
            acc_reg <= step_sel;
            // Hold at the terminal value rather than wrapping on W=32.
            if (count_reg != last_count) count_reg <= count_reg + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The result is only visible while it is valid.
  assign out_result = (state_reg == ST_DONE) ? res_sel : 32'd0;

endmodule

// File: tb/tb_xc_pclmul_fu.sv
// Directed and randomized bench for xc_pclmul_fu with a result scoreboard.
module tb_xc_pclmul_fu;

  logic        g_clk = 1'b0;
  logic        g_rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [2:0]  in_pw;
  logic        in_hi;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];

  xc_pclmul_fu dut (
    .g_clk      (g_clk),
    .g_rst      (g_rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_pw      (in_pw),
    .in_hi      (in_hi),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 g_clk = ~g_clk;

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Lane-by-lane reference: schoolbook carry-less product, then half select.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] pw, input logic hi);
    logic [31:0] r;
    logic [63:0] p;
    logic [63:0] mask;
    logic [63:0] al;
    int w;
    r = 32'd0;
    if (pw > 3'd4) return 32'd0;
    w = 32 >> pw;
    mask = (64'd1 << w) - 64'd1;
    for (int k = 0; k < 32 / w; k++) begin
      p  = 64'd0;
      al = ({32'd0, a} >> (w * k)) & mask;
      for (int i = 0; i < w; i++)
        if (b[w*k+i]) p = p ^ (al << i);
      if (hi) p = p >> w;
      r = r | 32'((p & mask) << (w * k));
    end
    return r;
  endfunction

  // Present one operation and complete the accept edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] pw, input logic hi, input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin tick(); n++; end
    if (in_ready !== 1'b1) check({tag, "_ready_timeout"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_rs1   = a;
    in_rs2   = b;
    in_pw    = pw;
    in_hi    = hi;
    tick();
    in_valid = 1'b0;
    // Operands must be ignored after the accepting edge.
    in_rs1   = $urandom;
    in_rs2   = $urandom;
    in_pw    = 3'($urandom_range(0, 7));
    in_hi    = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] pw,
                      input logic hi, input logic [31:0] exp, input int lat, input string tag);
    exp_t e;
    start(a, b, pw, hi, tag);
    e.res = exp;
    e.lat = lat;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Wait for the result, compare against the scoreboard head, optionally
  // hold backpressure for some cycles, then retire it.
  task automatic collect(input int hold);
    exp_t e;
    int cyc;
    e = sb.pop_front();
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    check({e.tag, "_latency"}, 32'(cyc), 32'(e.lat));
    check({e.tag, "_result"}, out_result, e.res);
    check({e.tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    $display("op %s: result=%h latency=%0d", e.tag, out_result, cyc);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({e.tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({e.tag, "_hold_result"}, out_result, e.res);
      check({e.tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check({e.tag, "_retire_valid"}, {31'd0, out_valid}, 32'd0);
    check({e.tag, "_retire_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({e.tag, "_retire_result"}, out_result, 32'd0);
  endtask

  task automatic watch_no_valid(input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rp;
    logic        rh;

    g_rst     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_rs1    = 32'd0;
    in_rs2    = 32'd0;
    in_pw     = 3'd0;
    in_hi     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    g_rst = 1'b0;
    tick();

    send(32'h00000003, 32'h00000003, 3'd0, 1'b0, 32'h00000005, 32, "pw0_lo_3x3");
    collect(0);
    send(32'h80000000, 32'h80000000, 3'd0, 1'b1, 32'h40000000, 32, "pw0_hi_msb");
    collect(0);
    send(32'h80000000, 32'h80000000, 3'd0, 1'b0, 32'h00000000, 32, "pw0_lo_msb");
    collect(0);
    send(32'h03030303, 32'h03030303, 3'd2, 1'b0, 32'h05050505, 8, "pw2_lo_lanes");
    collect(0);
    send(32'h000000FF, 32'h00000080, 3'd2, 1'b1, 32'h0000007F, 8, "pw2_hi_noleak");
    collect(0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 1'b0, 32'h55555555, 2, "pw4_lo_ones");
    collect(0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 1'b1, 32'h55555555, 2, "pw4_hi_ones");
    collect(0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 1'b1, 32'h00000000, 1, "pw5_reserved");
    collect(0);

    // Backpressure: hold the result for 5 cycles in DONE.
    out_ready = 1'b0;
    send(32'h0000ABCD, 32'h00001234, 3'd1, 1'b0,
         model(32'h0000ABCD, 32'h00001234, 3'd1, 1'b0), 16, "pw1_backpressure");
    collect(5);

    // Randomized operations against the reference model.
    for (int t = 0; t < 8; t++) begin
      ra = $urandom;
      rb = $urandom;
      rp = 3'($urandom_range(0, 5));
      rh = 1'($urandom_range(0, 1));
      send(ra, rb, rp, rh, model(ra, rb, rp, rh), (rp > 3'd4) ? 1 : (32 >> rp),
           $sformatf("rand%0d_pw%0d_hi%0d", t, rp, rh));
      collect(0);
    end

    // Flush at BUSY step 10: the aborted operation never completes.
    start(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b1, "flush_op");
    for (int s = 0; s < 10; s++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    watch_no_valid("flush_no_valid");
    send(32'h00000003, 32'h00000003, 3'd0, 1'b0, 32'h00000005, 32, "after_flush");
    collect(0);

    // Reset at BUSY step 10.
    start(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b0, "reset_op");
    for (int s = 0; s < 10; s++) tick();
    g_rst = 1'b1;
    #2;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    g_rst = 1'b0;
    tick();
    check("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
    watch_no_valid("rst_no_valid");
    send(32'h00000003, 32'h00000003, 3'd0, 1'b0, 32'h00000005, 32, "after_reset");
    collect(0);

    // Flush and out_ready together in DONE: flush wins, result dropped.
    out_ready = 1'b0;
    start(32'h0000000F, 32'h0000000F, 3'd4, 1'b0, "flush_done");
    for (int c = 0; c < 10 && out_valid !== 1'b1; c++) tick();
    check("flush_done_valid_before", {31'd0, out_valid}, 32'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_done_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_done_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_done_result", out_result, 32'd0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
